// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell shared by the serial engine.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full adder sequenced over WIDTH bits,
// LSB first, with a registered carry. All outputs are registered.
//
//  state   | meaning
//  --------+----------------------------------------------
//  ST_IDLE | waiting for start, result held
//  ST_RUN  | shifting one bit per clock through the adder
//  ST_DONE | result valid for one cycle, start re-accepted
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sequencer: accept operands, shift them through the adder, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and force the carry-in.
            state   <= ST_RUN;
            a_sh    <= a;
            b_sh    <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
            count   <= '0;
            busy    <= 1'b1;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum     <= {fa_s, sum[WIDTH-1:1]};
          carry_q <= fa_co;
          count   <= count + 1'b1;
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_co;
            ovf   <= carry_q ^ fa_co;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
